// File: rtl/axil_adder_master.sv
// -----------------------------------------------------------------------------
// axil_adder_master
//
// AXI4-Lite master that drives an adder slave. Each accepted command writes
// operand A to ADDR_A, operand B to ADDR_B, reads the sum back from ADDR_RES
// and returns it on the res_* port. Only one transaction is in flight at a time.
//
// Ports
//   m1_axi_aclk, m1_axi_aresetn : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready, cmd_a/cmd_b : operand pair input handshake
//   res_valid/res_ready, res_data, res_err : result output handshake; res_err
//       is set when any write or read response in the transaction was not OKAY
//   m1_axi_aw* / m1_axi_w* / m1_axi_b* : write address, data and response
//   m1_axi_ar* / m1_axi_r*             : read address and data
//
// Every handshake and address/data output comes straight from a flop. The
// combinational process computes the next value of each output register, so
// outputs change only on a clock edge or on reset.
// -----------------------------------------------------------------------------
module axil_adder_master #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_A     = 8'h00,
  parameter logic [ADDR_WIDTH-1:0] ADDR_B     = 8'h04,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RES   = 8'h18
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    WR_B    = 3'd2,
    BRESP_A = 3'd3,
    BRESP_B = 3'd4,
    RD_ADDR = 3'd5,
    RD_DATA = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                  state_r,     state_s;
  logic [DATA_WIDTH-1:0]   b_r,         b_s;
  logic                    cmd_ready_r, cmd_ready_s;
  logic                    awvalid_r,   awvalid_s;
  logic [ADDR_WIDTH-1:0]   awaddr_r,    awaddr_s;
  logic                    wvalid_r,    wvalid_s;
  logic [DATA_WIDTH-1:0]   wdata_r,     wdata_s;
  logic                    bready_r,    bready_s;
  logic                    arvalid_r,   arvalid_s;
  logic [ADDR_WIDTH-1:0]   araddr_r,    araddr_s;
  logic                    rready_r,    rready_s;
  logic                    res_valid_r, res_valid_s;
  logic [DATA_WIDTH-1:0]   res_data_r,  res_data_s;
  logic                    res_err_r,   res_err_s;

  // A channel is "done" once its valid is low (handshake already taken) or
  // its handshake completes this cycle; the write phase ends when both are.
  logic aw_done_s;
  logic w_done_s;
  logic bresp_bad_s;
  logic rresp_bad_s;

  // Handshake-completion and response-error decode.
  always_comb begin
    aw_done_s   = !awvalid_r || m1_axi_awready;
    w_done_s    = !wvalid_r  || m1_axi_wready;
    bresp_bad_s = (m1_axi_bresp != 2'b00);
    rresp_bad_s = (m1_axi_rresp != 2'b00);
  end

  // Next-state and next-output-register logic; every register holds by default.
  always_comb begin
    state_s     = state_r;
    b_s         = b_r;
    cmd_ready_s = cmd_ready_r;
    awvalid_s   = awvalid_r;
    awaddr_s    = awaddr_r;
    wvalid_s    = wvalid_r;
    wdata_s     = wdata_r;
    bready_s    = bready_r;
    arvalid_s   = arvalid_r;
    araddr_s    = araddr_r;
    rready_s    = rready_r;
    res_valid_s = res_valid_r;
    res_data_s  = res_data_r;
    res_err_s   = res_err_r;

    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          // Operand A is latched directly into the write-data register.
          b_s         = cmd_b;
          res_err_s   = 1'b0;
          cmd_ready_s = 1'b0;
          awvalid_s   = 1'b1;
          wvalid_s    = 1'b1;
          awaddr_s    = ADDR_A;
          wdata_s     = cmd_a;
          state_s     = WR_A;
        end else begin
          // Also raises cmd_ready on the first edge after reset release.
          cmd_ready_s = 1'b1;
        end
      end

      WR_A, WR_B: begin
        if (awvalid_r && m1_axi_awready) begin
          awvalid_s = 1'b0;
        end else begin
          awvalid_s = awvalid_r;
        end
        if (wvalid_r && m1_axi_wready) begin
          wvalid_s = 1'b0;
        end else begin
          wvalid_s = wvalid_r;
        end
        if (aw_done_s && w_done_s) begin
          bready_s = 1'b1;
          state_s  = (state_r == WR_A) ? BRESP_A : BRESP_B;
        end else begin
          state_s  = state_r;
        end
      end

      BRESP_A: begin
        if (m1_axi_bvalid) begin
          bready_s  = 1'b0;
          res_err_s = res_err_r | bresp_bad_s;
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
          awaddr_s  = ADDR_B;
          wdata_s   = b_r;
          state_s   = WR_B;
        end else begin
          state_s   = BRESP_A;
        end
      end

      BRESP_B: begin
        if (m1_axi_bvalid) begin
          bready_s  = 1'b0;
          res_err_s = res_err_r | bresp_bad_s;
          arvalid_s = 1'b1;
          araddr_s  = ADDR_RES;
          state_s   = RD_ADDR;
        end else begin
          state_s   = BRESP_B;
        end
      end

      RD_ADDR: begin
        if (m1_axi_arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = RD_DATA;
        end else begin
          state_s   = RD_ADDR;
        end
      end

      RD_DATA: begin
        if (m1_axi_rvalid) begin
          rready_s    = 1'b0;
          res_data_s  = m1_axi_rdata;
          res_err_s   = res_err_r | rresp_bad_s;
          res_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s     = RD_DATA;
        end
      end

      DONE: begin
        if (res_ready) begin
          res_valid_s = 1'b0;
          cmd_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s     = DONE;
        end
      end

      default: begin
        state_s     = IDLE;
        cmd_ready_s = 1'b0;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        res_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state_r     <= IDLE;
      b_r         <= '0;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      awaddr_r    <= '0;
      wvalid_r    <= 1'b0;
      wdata_r     <= '0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      araddr_r    <= '0;
      rready_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      b_r         <= b_s;
      cmd_ready_r <= cmd_ready_s;
      awvalid_r   <= awvalid_s;
      awaddr_r    <= awaddr_s;
      wvalid_r    <= wvalid_s;
      wdata_r     <= wdata_s;
      bready_r    <= bready_s;
      arvalid_r   <= arvalid_s;
      araddr_r    <= araddr_s;
      rready_r    <= rready_s;
      res_valid_r <= res_valid_s;
      res_data_r  <= res_data_s;
      res_err_r   <= res_err_s;
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign res_valid      = res_valid_r;
  assign res_data       = res_data_r;
  assign res_err        = res_err_r;
  assign m1_axi_awaddr  = awaddr_r;
  assign m1_axi_awvalid = awvalid_r;
  assign m1_axi_wdata   = wdata_r;
  assign m1_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
  assign m1_axi_wvalid  = wvalid_r;
  assign m1_axi_bready  = bready_r;
  assign m1_axi_araddr  = araddr_r;
  assign m1_axi_arvalid = arvalid_r;
  assign m1_axi_rready  = rready_r;

endmodule

// File: tb/tb_axil_adder_master.sv
// -----------------------------------------------------------------------------
// tb_axil_adder_master
//
// Drives axil_adder_master against a behavioural AXI4-Lite adder slave with
// programmable ready delays and response codes. A table of operand vectors is
// applied in a loop; hand-written sequences cover write-channel skew, result
// back-pressure, reset during the read and back-to-back commands.
// -----------------------------------------------------------------------------
module tb_axil_adder_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        res_valid, res_ready, res_err;
  logic [31:0] res_data;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_adder_master dut (
    .m1_axi_aclk    (clk),
    .m1_axi_aresetn (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err),
    .m1_axi_awaddr  (awaddr),
    .m1_axi_awvalid (awvalid),
    .m1_axi_awready (awready),
    .m1_axi_wdata   (wdata),
    .m1_axi_wstrb   (wstrb),
    .m1_axi_wvalid  (wvalid),
    .m1_axi_wready  (wready),
    .m1_axi_bresp   (bresp),
    .m1_axi_bvalid  (bvalid),
    .m1_axi_bready  (bready),
    .m1_axi_araddr  (araddr),
    .m1_axi_arvalid (arvalid),
    .m1_axi_arready (arready),
    .m1_axi_rdata   (rdata),
    .m1_axi_rresp   (rresp),
    .m1_axi_rvalid  (rvalid),
    .m1_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  int          aw_delay = 0, w_delay = 0;
  logic [1:0]  bresp_a_cfg = 2'b00, bresp_b_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_wait, w_wait;
  logic        aw_got, w_got;
  logic [7:0]  aw_q, araddr_seen;
  logic [31:0] w_q, reg_a, reg_b;
  int          cnt_a = 0, cnt_b = 0, cnt_bad = 0, cnt_rd = 0, bad_strb = 0;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid;

  wire        aw_hs    = awvalid && awready;
  wire        w_hs     = wvalid && wready;
  wire        aw_have  = aw_got || aw_hs;
  wire        w_have   = w_got || w_hs;
  wire [7:0]  cur_addr = aw_got ? aw_q : awaddr;
  wire [31:0] cur_data = w_got ? w_q : wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (w_hs && wstrb != 4'hF) bad_strb <= bad_strb + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_have && w_have) begin
        if (cur_addr == 8'h00) begin reg_a <= cur_data; cnt_a <= cnt_a + 1; end
        else if (cur_addr == 8'h04) begin reg_b <= cur_data; cnt_b <= cnt_b + 1; end
        else cnt_bad <= cnt_bad + 1;
        bvalid <= 1'b1;
        bresp  <= (cur_addr == 8'h04) ? bresp_b_cfg : bresp_a_cfg;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_q <= awaddr; end
        if (w_hs)  begin w_got  <= 1'b1; w_q  <= wdata;  end
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= reg_a + reg_b; rresp <= rresp_cfg;
        araddr_seen <= araddr; cnt_rd <= cnt_rd + 1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- protocol monitors ----------------
  logic       aw_hold_q = 1'b0, w_hold_q = 1'b0;
  logic [7:0] awaddr_q2;
  logic [31:0] wdata_q2;
  int stab_viol = 0, ar_viol = 0, aw_only = 0;

  always @(posedge clk) begin
    aw_hold_q <= awvalid && !awready;
    w_hold_q  <= wvalid && !wready;
    awaddr_q2 <= awaddr;
    wdata_q2  <= wdata;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_hold_q && (!awvalid || awaddr != awaddr_q2)) stab_viol <= stab_viol + 1;
      if (w_hold_q && (!wvalid || wdata != wdata_q2)) stab_viol <= stab_viol + 1;
      if ((awvalid || wvalid) && arvalid) ar_viol <= ar_viol + 1;
      if (awvalid && !wvalid) aw_only <= aw_only + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic start_cmd(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int k = 0;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    check("cmd_ready timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Latency = rising edges from the accepting edge through the edge that
  // raises res_valid, both inclusive.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check("res_valid timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output logic err, output int lat);
    start_cmd(a, b, 1'b0);
    wait_res(lat);
    data = res_data;
    err  = res_err;
    consume();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  bra;
    logic [1:0]  brb;
    logic [1:0]  rr;
    logic [31:0] exp_sum;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, ca, cb, cr, ao;

    vecs[0] = '{32'd39,         32'd40,         2'b00, 2'b00, 2'b00, 32'd79,         1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          2'b00, 2'b00, 2'b00, 32'd0,          1'b0};
    vecs[2] = '{32'd1000,       32'd2345,       2'b00, 2'b10, 2'b00, 32'd3345,       1'b1};
    vecs[3] = '{32'h1234_5678,  32'h1111_1111,  2'b00, 2'b00, 2'b00, 32'h2345_6789,  1'b0};
    vecs[4] = '{32'd7,          32'd8,          2'b00, 2'b00, 2'b11, 32'd15,         1'b1};
    vecs[5] = '{32'h8000_0000,  32'h8000_0000,  2'b01, 2'b00, 2'b00, 32'd0,          1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; res_ready = 1'b0;

    // Reset values, including across clock edges while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {56'd0, cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid, res_err}, 64'd0);
    check("reset data/addr", {res_data, wdata} | {48'd0, awaddr, araddr}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready first edge", 64'(cmd_ready), 64'd1);

    // Table-driven vectors against a zero-wait slave.
    for (int i = 0; i < 6; i++) begin
      bresp_a_cfg = vecs[i].bra; bresp_b_cfg = vecs[i].brb; rresp_cfg = vecs[i].rr;
      ca = cnt_a; cb = cnt_b; cr = cnt_rd;
      run_txn(vecs[i].a, vecs[i].b, d, e, lat);
      check($sformatf("vec%0d res_data", i), 64'(d), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d res_err", i), 64'(e), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd7);
      check($sformatf("vec%0d writes", i), {32'(cnt_a - ca), 32'(cnt_b - cb)}, {32'd1, 32'd1});
      check($sformatf("vec%0d reads", i), 64'(cnt_rd - cr), 64'd1);
      check($sformatf("vec%0d slave regs", i), {reg_a, reg_b}, {vecs[i].a, vecs[i].b});
      check($sformatf("vec%0d araddr", i), 64'(araddr_seen), 64'h18);
      check($sformatf("vec%0d idle after", i), {62'd0, cmd_ready, res_valid}, 64'd2);
    end
    bresp_a_cfg = 2'b00; bresp_b_cfg = 2'b00; rresp_cfg = 2'b00;

    // wready comes 3 cycles before awready on both writes.
    aw_delay = 3; ca = cnt_a; cb = cnt_b; ao = aw_only;
    run_txn(32'd11, 32'd22, d, e, lat);
    check("skew res_data", 64'(d), 64'd33);
    check("skew latency", 64'(lat), 64'd13);
    check("skew one write each", {32'(cnt_a - ca), 32'(cnt_b - cb)}, {32'd1, 32'd1});
    check("skew aw-only cycles", 64'(aw_only - ao), 64'd6);
    aw_delay = 0;

    // Result held back for 5 cycles.
    start_cmd(32'd100, 32'd23, 1'b0);
    wait_res(lat);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d", k), {res_data, 29'd0, res_valid, res_err, cmd_ready}, {32'd123, 29'd0, 3'b100});
      @(posedge clk); #1;
    end
    consume();
    check("hold released", {62'd0, res_valid, cmd_ready}, 64'd1);

    // Reset pulsed while waiting for read data.
    start_cmd(32'd9, 32'd9, 1'b0);
    lat = 0;
    while (!rready && lat < 100) begin @(posedge clk); #1; lat++; end
    check("reach RD_DATA", 64'(rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async abort", {57'd0, cmd_ready, awvalid, wvalid, bready, arvalid, rready, res_valid}, 64'd0);
    @(posedge clk); #1;
    check("in reset", {62'd0, cmd_ready, res_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset", {62'd0, cmd_ready, res_valid}, 64'd2);
    run_txn(32'd5, 32'd6, d, e, lat);
    check("post-reset txn", {d, 31'd0, e}, {32'd11, 32'd0});
    check("post-reset latency", 64'(lat), 64'd7);

    // Back-to-back with cmd_valid held high.
    start_cmd(32'd1, 32'd2, 1'b1);
    wait_res(lat);
    check("b2b first", {res_data, 31'd0, cmd_ready}, {32'd3, 32'd0});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cmd_a = 32'd50; cmd_b = 32'd60;
    check("b2b consumed", {62'd0, res_valid, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b second accepted", {wdata, 29'd0, cmd_ready, awvalid, wvalid}, {32'd50, 32'd3});
    wait_res(lat);
    check("b2b second", {res_data, 31'd0, res_err}, {32'd110, 32'd0});
    check("b2b second latency", 64'(lat), 64'd7);
    consume();

    // Whole-run protocol monitors.
    check("stability", 64'(stab_viol), 64'd0);
    check("write/read overlap", 64'(ar_viol), 64'd0);
    check("stray writes", 64'(cnt_bad), 64'd0);
    check("wstrb", 64'(bad_strb), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_adder_master.md
AXIL_ADDER_MASTER -- requirements
Module: axil_adder_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 8, address width; ADDR_A, 8'h00, operand-A register; ADDR_B, 8'h04, operand-B register; ADDR_RES, 8'h18, result register.
REQ-002 Ports SHALL be, in this order (name, direction, width, meaning):
- m1_axi_aclk, in, 1, single clock; all logic on the rising edge.
- m1_axi_aresetn, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, operand pair offered.
- cmd_ready, out, 1, block accepts operands.
- cmd_a, in, DATA_WIDTH, operand A.
- cmd_b, in, DATA_WIDTH, operand B.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer takes result.
- res_data, out, DATA_WIDTH, sum read from slave.
- res_err, out, 1, a non-OKAY response occurred in this transaction.
- m1_axi_awaddr, out, ADDR_WIDTH; m1_axi_awvalid, out, 1; m1_axi_awready, in, 1.
- m1_axi_wdata, out, DATA_WIDTH; m1_axi_wstrb, out, DATA_WIDTH/8; m1_axi_wvalid, out, 1; m1_axi_wready, in, 1.
- m1_axi_bresp, in, 2; m1_axi_bvalid, in, 1; m1_axi_bready, out, 1.
- m1_axi_araddr, out, ADDR_WIDTH; m1_axi_arvalid, out, 1; m1_axi_arready, in, 1.
- m1_axi_rdata, in, DATA_WIDTH; m1_axi_rresp, in, 2; m1_axi_rvalid, in, 1; m1_axi_rready, out, 1.

Function
REQ-003 The block SHALL act as an AXI4-Lite master feeding the adder slave: write A, write B, read the result, then return it on the res_* port.
REQ-004 The FSM SHALL have states IDLE, WR_A, WR_B, BRESP_A, BRESP_B, RD_ADDR, RD_DATA and DONE.
REQ-005 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready the block SHALL latch cmd_a/cmd_b, clear the error flag and go to WR_A.
REQ-006 WR_A/WR_B SHALL assert awvalid and wvalid in the same cycle, with awaddr=ADDR_A/ADDR_B, wdata=A/B and wstrb all ones.
REQ-007 Each of awvalid and wvalid SHALL drop independently on its own handshake; the state SHALL advance only after both handshakes, in either order or the same cycle.
REQ-008 BRESP_x SHALL hold bready=1; on bvalid the block SHALL go to WR_B (from A) or RD_ADDR (from B).
REQ-009 RD_ADDR SHALL assert arvalid with araddr=ADDR_RES and go to RD_DATA on arready.
REQ-010 RD_DATA SHALL hold rready=1; on rvalid it SHALL capture rdata into res_data and go to DONE.
REQ-011 Any bresp or rresp not equal to 2'b00 SHALL set the sticky res_err; the sequence SHALL still complete.
REQ-012 DONE SHALL hold res_valid=1 with stable res_data/res_err until res_ready, then return to IDLE.
REQ-013 cmd_ready SHALL be 0 in every state except IDLE; at most one transaction SHALL be outstanding.
REQ-014 All AXI valid/ready outputs SHALL be registered; address/data outputs SHALL be stable while their valid is high.
REQ-015 Minimum latency with zero-wait slave SHALL be: accept to res_valid = 7 cycles.
REQ-016 The block SHALL not assert a write valid and arvalid in the same cycle.

Reset
REQ-017 While m1_axi_aresetn=0: state=IDLE; awvalid, wvalid, bready, arvalid, rready, res_valid and res_err = 0; res_data, awaddr, araddr and wdata = 0; cmd_ready = 0.
REQ-018 Reset asserted mid-transaction SHALL abort immediately with no completion signalled; after release, cmd_ready SHALL rise on the first clock edge.

Verification
REQ-019 Zero-wait slave, cmd A=39, B=40 -> writes to 0x00=39 and 0x04=40, read from 0x18, res_data=79, res_err=0, 7 cycles.
REQ-020 Slave raises wready 3 cycles before awready -> wvalid drops first, awvalid holds, and exactly one write is issued per address.
REQ-021 bresp=2'b10 on the B write -> read still performed and res_err=1; the next transaction starts with res_err=0.
REQ-022 res_ready held low 5 cycles -> res_valid/res_data stable, cmd_ready=0 throughout.
REQ-023 Reset pulsed during RD_DATA -> all valids 0 asynchronously, no res_valid, and a fresh command completes correctly afterwards.
REQ-024 Back-to-back commands with cmd_valid held high -> second accepted the cycle after the first result is consumed.
